// File: rtl/jtag_master.sv
// Host-side JTAG initiator: walks the target TAP from Run-Test/Idle through
// IR/DR scans, TAP reset or idle clocking, and returns the captured TDO bits.
module jtag_master #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        TLR,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic        tck,
  output logic        tms,
  output logic        tdi,
  input  logic        tdo
);

  localparam int unsigned   DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_HEAD, S_SHIFT, S_TAIL, S_RESP} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_op;
  logic [5:0]    r_len;
  logic [31:0]   r_data;
  logic [31:0]   r_cap;
  logic [31:0]   r_rsp_data;
  logic [DW-1:0] r_div;
  logic          r_hi;
  logic [5:0]    r_idx;
  logic          r_tms_hold;

  logic          w_active, w_accept, w_phase_end, w_pulse_end, w_sample;
  logic          w_scan, w_last, w_tms_cur;
  logic [5:0]    w_eff_len, w_phase_cnt;

  // Handshake, status, pin drive and pulse-phase decode
  always_comb begin
    w_active    = (r_state == S_HEAD) || (r_state == S_SHIFT) || (r_state == S_TAIL);
    cmd_ready   = (r_state == S_IDLE) || (r_state == S_RESP);
    busy        = w_active;
    rsp_valid   = (r_state == S_RESP);
    rsp_data    = r_rsp_data;
    tck         = w_active && r_hi;
    w_accept    = cmd_valid && cmd_ready;
    w_phase_end = (r_div == DIV_LAST);
    w_pulse_end = w_active && r_hi && w_phase_end;
    w_sample    = w_active && !r_hi && w_phase_end;
    w_scan      = (r_op == 2'b01) || (r_op == 2'b10);
    w_eff_len   = (cmd_len == 6'd0) ? 6'd1 : ((cmd_len > 6'd32) ? 6'd32 : cmd_len);

    w_phase_cnt = 6'd0;
    w_tms_cur   = 1'b0;
    case (r_state)
      S_HEAD: begin
        case (r_op)
          2'b00:   begin w_phase_cnt = 6'd6; w_tms_cur = (r_idx < 6'd5); end
          2'b01:   begin w_phase_cnt = 6'd4; w_tms_cur = (r_idx < 6'd2); end
          default: begin w_phase_cnt = 6'd3; w_tms_cur = (r_idx == 6'd0); end
        endcase
      end
      S_SHIFT: begin
        w_phase_cnt = r_len;
        w_tms_cur   = w_scan && (r_idx == r_len - 6'd1);
      end
      S_TAIL: begin
        w_phase_cnt = 6'd2;
        w_tms_cur   = (r_idx == 6'd0);
      end
      default: ;
    endcase
    w_last = (r_idx == w_phase_cnt - 6'd1);

    // between commands tms parks at its last driven level
    tms = w_active ? w_tms_cur : r_tms_hold;
    // op 11 loads zero data, so tdi stays low for idle clocking
    tdi = (r_state == S_SHIFT) && r_data[0];
  end

  // Next-state: step to the next non-empty phase at the end of its last pulse
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_RESP: begin
        if (w_accept) w_state_nxt = (cmd_op == 2'b11) ? S_SHIFT : S_HEAD;
        else          w_state_nxt = S_IDLE;
      end
      S_HEAD:  if (w_pulse_end && w_last) w_state_nxt = (r_op == 2'b00) ? S_RESP : S_SHIFT;
      S_SHIFT: if (w_pulse_end && w_last) w_state_nxt = w_scan ? S_TAIL : S_RESP;
      S_TAIL:  if (w_pulse_end && w_last) w_state_nxt = S_RESP;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (TLR) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Command latch, TCK phase counter, shift/capture datapath and response
  always_ff @(posedge clk) begin
    if (TLR) begin
      r_op       <= '0;
      r_len      <= '0;
      r_data     <= '0;
      r_cap      <= '0;
      r_rsp_data <= '0;
      r_div      <= '0;
      r_hi       <= 1'b0;
      r_idx      <= '0;
      r_tms_hold <= 1'b1;
    end else begin
      if (w_accept) begin
        r_op       <= cmd_op;
        r_len      <= w_eff_len;
        r_data     <= (cmd_op == 2'b11) ? '0 : cmd_data;
        r_cap      <= '0;
        r_div      <= '0;
        r_hi       <= 1'b0;
        r_idx      <= '0;
        // every complete command leaves tms low
        r_tms_hold <= 1'b0;
      end else if (w_active) begin
        if (w_phase_end) begin
          r_div <= '0;
          r_hi  <= ~r_hi;
        end else begin
          r_div <= r_div + 1'b1;
        end
        if (w_sample && (r_state == S_SHIFT) && w_scan)
          r_cap[r_idx[4:0]] <= tdo;
        if (w_pulse_end) begin
          r_idx <= w_last ? 6'd0 : r_idx + 6'd1;
          if (r_state == S_SHIFT) r_data <= r_data >> 1;
        end
        if (w_state_nxt == S_RESP) r_rsp_data <= r_cap;
      end
    end
  end

endmodule

// File: tb/tb_jtag_master.sv
// Self-checking bench for jtag_master: vector table plus scoreboard of
// expected response words, and a pin monitor recording tms/tdi per TCK pulse.
module tb_jtag_master;

  localparam int unsigned CLK_DIV = 2;

  logic        clk = 1'b0;
  logic        TLR;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy, tck, tms, tdi, tdo;
  logic [1:0]  tdo_mode;  // 0 loopback, 1 tied high, 2 tied low

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [31:0] sb_q[$];

  logic [63:0] mon_tms, mon_tdi;
  int          mon_n = 0;
  logic        prev_tck = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  len;
    logic [31:0] data;
    logic [1:0]  mode;
    logic [31:0] rsp;
    int          pulses;
  } vec_t;

  vec_t vecs[11];

  jtag_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .TLR(TLR), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
  );

  assign tdo = (tdo_mode == 2'd0) ? tdi : (tdo_mode == 2'd1);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record tms/tdi once per tck pulse (they are stable for the whole pulse)
  always @(negedge clk) begin
    if (tck && !prev_tck && mon_n < 64) begin
      mon_tms[mon_n] = tms;
      mon_tdi[mon_n] = tdi;
      mon_n++;
    end
    prev_tck = tck;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // expected tms/tdi pulse sequences straight from the TAP navigation rules
  function automatic void model(input logic [1:0] op, input logic [5:0] len,
                                input logic [31:0] data, output int n,
                                output logic [63:0] etms, output logic [63:0] etdi);
    int L;
    int h;
    L    = (len == 0) ? 1 : ((len > 32) ? 32 : int'(len));
    etms = '0;
    etdi = '0;
    h    = 0;
    if (op == 2'b00) begin
      etms = 64'h1F;
      n    = 6;
    end else begin
      if (op == 2'b01) begin etms = 64'h3; h = 4; end
      if (op == 2'b10) begin etms = 64'h1; h = 3; end
      if (op == 2'b11) begin
        n = L;
      end else begin
        for (int k = 0; k < L; k++) etdi[h+k] = data[k];
        etms[h+L-1] = 1'b1;
        etms[h+L]   = 1'b1;
        n = h + L + 2;
      end
    end
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) chk("ready_timeout", 64'(cmd_ready), 64'd1);
  endtask

  task automatic wait_rsp(output bit got);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                         input logic [1:0] mode, input logic [31:0] exp_rsp, input int exp_pulses);
    int          n;
    logic [63:0] et, ed;
    int          cacc;
    bit          got;
    model(op, len, data, n, et, ed);
    tdo_mode = mode;
    wait_ready();
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cacc      = cyc;
    mon_n     = 0;
    mon_tms   = '0;
    mon_tdi   = '0;
    sb_q.push_back(exp_rsp);
    wait_rsp(got);
    if (!got) begin
      chk("rsp_timeout", 64'd0, 64'd1);
      void'(sb_q.pop_front());
      return;
    end
    chk("rsp_data", 64'(rsp_data), 64'(sb_q.pop_front()));
    chk("pulse_count", 64'(mon_n), 64'(exp_pulses));
    chk("tms_seq", mon_tms, et);
    chk("tdi_seq", mon_tdi, ed);
    chk("latency", 64'(cyc - cacc + 1), 64'(2 * CLK_DIV * exp_pulses + 1));
    chk("resp_tck", 64'(tck), 64'd0);
    chk("resp_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("rsp_once", 64'(rsp_valid), 64'd0);
    chk("tms_park", 64'(tms), 64'd0);
    chk("rsp_hold", 64'(rsp_data), 64'(exp_rsp));
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          got;
    int          bad;
    int          cacc;
    int          nrsp;
    logic [63:0] et, ed;
    int          n;

    vecs[0]  = '{2'b00, 6'd0,  32'h0000_0000, 2'd0, 32'h0000_0000, 6};
    vecs[1]  = '{2'b10, 6'd8,  32'h0000_00A5, 2'd0, 32'h0000_00A5, 13};
    vecs[2]  = '{2'b01, 6'd4,  32'h0000_0003, 2'd1, 32'h0000_000F, 10};
    vecs[3]  = '{2'b10, 6'd40, 32'hFFFF_FFFF, 2'd0, 32'hFFFF_FFFF, 37};
    vecs[4]  = '{2'b11, 6'd0,  32'hDEAD_BEEF, 2'd1, 32'h0000_0000, 1};
    vecs[5]  = '{2'b01, 6'd32, 32'h1234_5678, 2'd0, 32'h1234_5678, 38};
    vecs[6]  = '{2'b10, 6'd1,  32'h0000_0002, 2'd0, 32'h0000_0000, 6};
    vecs[7]  = '{2'b10, 6'd5,  32'hFFFF_FFFF, 2'd1, 32'h0000_001F, 10};
    vecs[8]  = '{2'b01, 6'd6,  32'h0000_002A, 2'd2, 32'h0000_0000, 12};
    vecs[9]  = '{2'b11, 6'd3,  32'h0000_00FF, 2'd1, 32'h0000_0000, 3};
    vecs[10] = '{2'b00, 6'd5,  32'h0000_00FF, 2'd1, 32'h0000_0000, 6};

    TLR = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_data = '0; tdo_mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tck", 64'(tck), 64'd0);
    chk("rst_tms", 64'(tms), 64'd1);
    chk("rst_tdi", 64'(tdi), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    TLR = 1'b0;

    foreach (vecs[i])
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].mode, vecs[i].rsp, vecs[i].pulses);

    // backpressure: idle command held valid across a running DR scan
    tdo_mode = 2'd0;
    wait_ready();
    cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'h0000_00A5; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cacc = cyc; mon_n = 0; mon_tms = '0; mon_tdi = '0;
    sb_q.push_back(32'h0000_00A5);
    cmd_op = 2'b11; cmd_len = 6'd3; cmd_data = 32'hFFFF_FFFF;
    bad = 0; got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
      else if (!busy || cmd_ready) bad++;
    end
    chk("bp_rsp_seen", 64'(got), 64'd1);
    chk("bp_rsp_data", 64'(rsp_data), 64'(sb_q.pop_front()));
    chk("bp_busy_held", 64'(bad), 64'd0);
    chk("bp_scan_pulses", 64'(mon_n), 64'd13);
    chk("bp_latency", 64'(cyc - cacc + 1), 64'd53);
    @(negedge clk);
    mon_n = 0; mon_tms = '0; mon_tdi = '0;
    cacc = cyc;
    chk("bp_accepted_busy", 64'(busy), 64'd1);
    chk("bp_accepted_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    sb_q.push_back(32'h0);
    model(2'b11, 6'd3, 32'hFFFF_FFFF, n, et, ed);
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    chk("bp_idle_rsp_seen", 64'(got), 64'd1);
    chk("bp_idle_rsp_data", 64'(rsp_data), 64'(sb_q.pop_front()));
    chk("bp_idle_pulses", 64'(mon_n), 64'(n));
    chk("bp_idle_tms", mon_tms, et);
    chk("bp_idle_tdi", mon_tdi, ed);
    chk("bp_idle_latency", 64'(cyc - cacc + 1), 64'd13);

    // mid-op reset during SHIFT pulse 3 of a DR scan
    tdo_mode = 2'd1;
    wait_ready();
    cmd_op = 2'b10; cmd_len = 6'd8; cmd_data = 32'h0000_00F0; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; mon_n = 0;
    for (int i = 0; i < 200 && mon_n < 7; i++) @(negedge clk);
    chk("mid_reached_shift3", 64'(mon_n), 64'd7);
    TLR = 1'b1;
    @(negedge clk);
    TLR = 1'b0;
    chk("mid_tck", 64'(tck), 64'd0);
    chk("mid_tms", 64'(tms), 64'd1);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_ready", 64'(cmd_ready), 64'd1);
    chk("mid_rsp_data", 64'(rsp_data), 64'd0);
    nrsp = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("mid_no_rsp", 64'(nrsp), 64'd0);
    run_cmd(2'b00, 6'd0, 32'h0, 2'd0, 32'h0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Host-side JTAG initiator: drives TCK/TMS/TDI into a target TAP and captures TDO.
- Accepts one command at a time: TAP reset, IR scan, DR scan, or idle clocking.
- Generates the IEEE 1149.1 TMS navigation for each command; the TAP starts and ends every command in Run-Test/Idle.
- Returns the TDO bits captured during each scan as a response word; used by bench and system logic to exercise TAP-attached functional units.

Parameters:
- CLK_DIV, 2, clk cycles per TCK phase (low and high phase each); legal range >= 1.

Ports:
- clk  input  1  system clock.
- TLR  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  block can accept a command.
- cmd_op  input  2  operation: 00 TAP reset, 01 IR scan, 10 DR scan, 11 idle clocks.
- cmd_len  input  6  bit count (scan ops) or TCK count (idle op).
- cmd_data  input  32  TDI data, LSB shifted first.
- rsp_valid  output  1  one-cycle pulse when a command completes.
- rsp_data  output  32  captured TDO, LSB = first bit captured.
- busy  output  1  command in progress.
- tck  output  1  JTAG clock.
- tms  output  1  JTAG mode select.
- tdi  output  1  JTAG data in.
- tdo  input  1  JTAG data out from target.

Behaviour:
- Reset is synchronous and active-high.
  - On a clk edge with TLR=1: tck=0, tms=1, tdi=0, rsp_valid=0, rsp_data=0, busy=0, cmd_ready=1, FSM=IDLE.
  - This aborts any command in progress with no rsp_valid. The target TAP state is then undefined; the host must issue op 00.
- Handshake:
  - A command is accepted on a clk edge with cmd_valid && cmd_ready.
  - All cmd_* fields are registered at acceptance.
  - cmd_ready=0 and busy=1 from the next cycle until rsp_valid.
  - cmd_ready returns to 1 in the same cycle rsp_valid is high.
- Length rules:
  - Effective length L: cmd_len=0 gives L=1; cmd_len>32 gives L=32; otherwise L=cmd_len.
  - L also applies to op 11.
- TCK pulse timing:
  - tck idles low.
  - Each pulse is CLK_DIV cycles low followed by CLK_DIV cycles high.
  - tms and tdi update on the first cycle of the low phase.
  - tdo is sampled on the clk edge where tck goes 0->1.
  - Pulses within a command are back-to-back.
- FSM states: IDLE -> HEAD -> SHIFT -> TAIL -> RESP -> IDLE. An empty phase is skipped.
- TMS sequence per op:
  - op 00: HEAD 6 pulses, tms 1,1,1,1,1,0; no SHIFT or TAIL; 6 pulses total.
  - op 01: HEAD tms 1,1,0,0; SHIFT L pulses with tms=0, last pulse tms=1; TAIL tms 1,0. Total L+6 pulses.
  - op 10: HEAD tms 1,0,0; SHIFT as op 01; TAIL tms 1,0. Total L+5 pulses.
  - op 11: SHIFT-only, L pulses with tms=0, tdi=0; no capture.
- Data rules:
  - During SHIFT pulse k (k=0..L-1), tdi = cmd_data[k].
  - tdo sampled on that pulse's rising edge goes to rsp_data[k].
  - rsp_data bits >= L are 0.
  - tdi=0 outside SHIFT.
- Completion:
  - RESP lasts one cycle, entered on the cycle after the last pulse's high phase ends.
  - In RESP: rsp_valid=1, tck=0.
  - rsp_data holds its value until the next command completes.
  - rsp_data=0 for op 00 and op 11.
- tms holds its last driven value between commands: 0 after every complete command, 1 after reset.
- cmd_valid while busy is ignored, not queued.
- TLR asserted in the same cycle as RESP: reset wins, and rsp_valid does not pulse.

Test Plan:
- TAP reset: CLK_DIV=2, op 00 -> 6 tck pulses, tms 1,1,1,1,1,0; rsp_valid at cycle 25 after acceptance with rsp_data=0.
- DR scan with tdo looped to tdi: op 10, len 8, data 0x000000A5.
  - 13 pulses; tms 1,0,0, then 0 x7, then 1,1,0.
  - tdi during SHIFT is 1,0,1,0,0,1,0,1.
  - rsp_data=0x000000A5.
- IR scan with tdo tied 1: op 01, len 4, data 0x3.
  - 10 pulses; tms 1,1,0,0,0,0,0,1,1,0.
  - tdi 1,1,0,0.
  - rsp_data=0x0000000F.
- Length clamp: op 10, len 40, data 0xFFFFFFFF, tdo looped -> 37 pulses, rsp_data=0xFFFFFFFF. Then op 11, len 0 -> 1 pulse with tms=0.
- Backpressure: hold cmd_valid with op 11 len 3 across a running DR scan -> not accepted until the cycle after rsp_valid; then exactly 3 pulses.
- Mid-op reset: assert TLR for 1 cycle during SHIFT pulse 3 of a DR scan.
  - Next cycle: tck=0, tms=1, busy=0, cmd_ready=1.
  - No rsp_valid pulse.
  - A following op 00 completes normally.
